// File: rtl/reg_index_encoder_if.sv
// reg_index_encoder_if
//   Bundles the two valid/ready channels of the register index encoder.
//   Request channel (producer -> encoder):
//     req_valid, req_vec  : bitmask offered by the producer
//     req_ready           : encoder can take a new bitmask
//   Index channel (encoder -> consumer):
//     idx_valid, idx, idx_last : register index being offered
//     idx_ready                : consumer takes the index this cycle
//   Handshake rule for both channels: a transfer happens on a rising clock
//   edge where valid && ready are both high. Once valid is raised, the
//   payload stays stable and valid stays high until that transfer (only a
//   flush or reset may withdraw it). Ready may change freely.
//   Modports: master = producer/consumer side, slave = encoder side.
interface reg_index_encoder_if #(
  parameter int N_REGS = 32,
  parameter int IDX_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [N_REGS-1:0] req_vec;
  logic              idx_valid;
  logic              idx_ready;
  logic [IDX_W-1:0]  idx;
  logic              idx_last;

  modport master (
    output req_valid, req_vec, idx_ready,
    input  req_ready, idx_valid, idx, idx_last
  );

  modport slave (
    input  req_valid, req_vec, idx_ready,
    output req_ready, idx_valid, idx, idx_last
  );
endinterface

// File: rtl/reg_index_encoder.sv
// reg_index_encoder
//   Sequential N_REGS-to-IDX_W encoder: takes a register bitmask and emits
//   the index of every set bit, lowest first, one per index handshake.
//   Ports:
//     clk       : system clock, rising edge
//     reset_n   : asynchronous active-low reset
//     bus       : slave side of reg_index_encoder_if (request + index channels)
//     flush     : synchronous abort of the current scan, no done pulse
//     busy      : scan in progress
//     done      : one-cycle pulse when a bitmask completes (empty ones too)
//     dbg_state : current FSM state, 0 = IDLE, 1 = SCAN
//   All outputs derive from registered state only.
module reg_index_encoder #(
  parameter int N_REGS  = 32,
  parameter int IDX_W   = 5,
  parameter int MASK_ZR = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  reg_index_encoder_if.slave    bus,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic                  dbg_state
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t            state;
  logic [N_REGS-1:0] pending;
  logic [N_REGS-1:0] masked;
  logic [IDX_W-1:0]  idx_enc;
  logic              last_bit;

  // Bit N_REGS-1 is the zero register when MASK_ZR is set; it never has
  // anything to write back, so drop it before deciding whether the mask is empty.
  always_comb begin
    masked = bus.req_vec;
    if (MASK_ZR != 0) masked[N_REGS-1] = 1'b0;
  end

  // Lowest set bit wins: scan from the top so the last hit is the lowest.
  always_comb begin
    idx_enc = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (pending[i]) idx_enc = IDX_W'(i);
    end
  end

  // Exactly one bit set: clearing the lowest bit leaves nothing.
  assign last_bit = (pending != '0) &&
                    ((pending & (pending - N_REGS'(1))) == '0);

  assign bus.req_ready = (state == IDLE);
  assign bus.idx_valid = (state == SCAN);
  assign bus.idx       = idx_enc;
  assign bus.idx_last  = last_bit;
  assign busy          = (state == SCAN);
  assign dbg_state     = (state == SCAN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pending <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state   <= IDLE;
        pending <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.req_valid) begin
              if (masked != '0) begin
                pending <= masked;
                state   <= SCAN;
              end else begin
                done <= 1'b1;
              end
            end
          end
          SCAN: begin
            if (bus.idx_ready) begin
              // Clears exactly the bit currently presented on idx.
              pending <= pending & (pending - N_REGS'(1));
              if (last_bit) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state   <= IDLE;
            pending <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_index_encoder.sv
module tb_reg_index_encoder;

  localparam int N_REGS = 32;
  localparam int IDX_W  = 5;

  logic clk;
  logic reset_n;
  logic flush;
  logic busy;
  logic done;
  logic dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [IDX_W-1:0] exp_q[$];

  reg_index_encoder_if #(.N_REGS(N_REGS), .IDX_W(IDX_W)) bus ();

  reg_index_encoder #(.N_REGS(N_REGS), .IDX_W(IDX_W), .MASK_ZR(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] vec;
    int          count;
    logic [4:0]  first;
    logic [4:0]  last;
  } vec_t;

  vec_t vecs[9];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge. Offers one bitmask with idx_ready high,
  // collects every index and checks it against the bit-walk scoreboard and
  // the hand-computed count/first/last, then the done pulse.
  task automatic run_vec(input logic [31:0] vec, input int count,
                         input logic [4:0] first, input logic [4:0] last);
    int got;
    int cycles;
    logic [4:0] got_first;
    logic [4:0] got_last;
    logic [4:0] e;
    exp_q.delete();
    for (int i = 0; i < N_REGS; i++) begin
      if (vec[i] && i != N_REGS - 1) exp_q.push_back(5'(i));
    end
    bus.req_valid = 1'b1;
    bus.req_vec   = vec;
    bus.idx_ready = 1'b1;
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_vec   = '0;
    got = 0;
    cycles = 0;
    got_first = '0;
    got_last = '0;
    @(negedge clk);
    while (bus.idx_valid && cycles < 40) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 5'h1f;
      check("idx", 32'(bus.idx), 32'(e));
      check("idx_last", 32'(bus.idx_last), 32'(exp_q.size() == 0));
      check("busy_scan", 32'(busy), 32'd1);
      check("req_ready_scan", 32'(bus.req_ready), 32'd0);
      if (got == 0) got_first = bus.idx;
      got_last = bus.idx;
      got++;
      cycles++;
      @(negedge clk);
    end
    check("count", 32'(got), 32'(count));
    if (count > 0) begin
      check("first", 32'(got_first), 32'(first));
      check("last", 32'(got_last), 32'(last));
    end
    check("done_pulse", 32'(done), 32'd1);
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    check("done_low", 32'(done), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{32'h0000_0000, 0,  5'd0,  5'd0};
    vecs[1] = '{32'h8000_0025, 3,  5'd0,  5'd5};
    vecs[2] = '{32'hFFFF_FFFF, 31, 5'd0,  5'd30};
    vecs[3] = '{32'h8000_0000, 0,  5'd0,  5'd0};
    vecs[4] = '{32'h0000_0001, 1,  5'd0,  5'd0};
    vecs[5] = '{32'h4000_0000, 1,  5'd30, 5'd30};
    vecs[6] = '{32'h0000_0110, 2,  5'd4,  5'd8};
    vecs[7] = '{32'h7FFF_FFFE, 30, 5'd1,  5'd30};
    vecs[8] = '{32'hA5A5_0000, 7,  5'd16, 5'd29};

    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_vec   = '0;
    bus.idx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_idx_valid", 32'(bus.idx_valid), 32'd0);
    check("rst_idx", 32'(bus.idx), 32'd0);
    check("rst_idx_last", 32'(bus.idx_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 9; v++) begin
      run_vec(vecs[v].vec, vecs[v].count, vecs[v].first, vecs[v].last);
    end

    // Backpressure: idx=4 held for 3 stalled cycles, then 4, 8.
    bus.req_valid = 1'b1;
    bus.req_vec   = 32'h0000_0110;
    bus.idx_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.idx_valid), 32'd1);
      check("bp_idx", 32'(bus.idx), 32'd4);
      check("bp_last", 32'(bus.idx_last), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.idx_ready = 1'b1;
    @(negedge clk);
    check("bp_idx_a", 32'(bus.idx), 32'd4);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_idx_b", 32'(bus.idx), 32'd8);
    check("bp_last_b", 32'(bus.idx_last), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_done", 32'(done), 32'd1);
    check("bp_valid_end", 32'(bus.idx_valid), 32'd0);
    @(posedge clk);
    #1;

    // Flush after first index of 0xF000.
    bus.req_valid = 1'b1;
    bus.req_vec   = 32'h0000_F000;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("fl_idx12", 32'(bus.idx), 32'd12);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("fl_idx13", 32'(bus.idx), 32'd13);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("fl_valid", 32'(bus.idx_valid), 32'd0);
    check("fl_ready", 32'(bus.req_ready), 32'd1);
    check("fl_no_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    run_vec(32'h0000_0001, 1, 5'd0, 5'd0);

    // Flush in IDLE drops a coincident request.
    bus.req_valid = 1'b1;
    bus.req_vec   = 32'h0000_0004;
    flush         = 1'b1;
    @(negedge clk);
    check("fli_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    flush         = 1'b0;
    @(negedge clk);
    check("fli_valid", 32'(bus.idx_valid), 32'd0);
    check("fli_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-scan of 0x00FF0000.
    bus.req_valid = 1'b1;
    bus.req_vec   = 32'h00FF_0000;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("ar_pre_idx", 32'(bus.idx), 32'd17);
    reset_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus.idx_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("ar_no_idx", 32'(bus.idx_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    run_vec(32'h0000_0006, 2, 5'd1, 5'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_index_encoder.md
Name: reg_index_encoder

Overview:
- Sequential 32-to-5 encoder that reverses the register-file write decoder.
- Accepts a 32-bit register bitmask, e.g. a dirty/pending-writeback scoreboard snapshot or a multi-register save list.
- Serially emits the 5-bit index of every set bit, lowest index first, one per accepted handshake.
- Feeds the writeback/spill path that drives the register file's 5-bit write address.

Parameters:
- N_REGS, 32, width of the request bitmask; must equal 2**IDX_W.
- IDX_W, 5, width of the emitted register index.
- MASK_ZR, 1, when 1 bit N_REGS-1 (X31/XZR) is forced to 0 on capture and never emitted.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request bitmask is valid.
- req_ready  output  1  block can accept a new bitmask.
- req_vec  input  N_REGS  register bitmask, bit i = register i.
- flush  input  1  synchronous abort of the current scan.
- idx_valid  output  1  idx holds a valid register index.
- idx_ready  input  1  consumer accepts idx this cycle.
- idx  output  IDX_W  index of the lowest pending set bit.
- idx_last  output  1  idx is the final index of this bitmask.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse when a bitmask completes, including an empty one.

Behaviour:
- Registered state: pending[N_REGS-1:0], state in {IDLE, SCAN}, done flop.
- Reset (reset_n low, asynchronous):
  - state=IDLE, pending=0, done=0.
  - Hence req_ready=1, idx_valid=0, idx=0, idx_last=0, busy=0.
- Capture in IDLE:
  - req_ready=1.
  - On edge with req_valid=1, capture masked = req_vec with bit 31 cleared if MASK_ZR.
  - masked!=0: pending<=masked, state<=SCAN.
  - masked==0: stay IDLE, done pulses next cycle, nothing is emitted.
- SCAN outputs:
  - req_ready=0, busy=1, idx_valid=1.
  - idx = position of the lowest set bit of pending (combinational priority encode of registered pending).
  - idx_last=1 iff pending has exactly one set bit.
- Handshake:
  - On edge with idx_valid && idx_ready, clear that bit in pending.
  - If idx_last: state<=IDLE, done<=1 for one cycle, req_ready=1 from the next cycle.
  - No handshake: idx/idx_last hold stable; valid never drops without acceptance except on flush/reset.
- Throughput and latency:
  - With idx_ready held high, one index per cycle.
  - A bitmask with k set bits occupies the block for exactly k cycles after capture.
  - Latency: bitmask accepted at edge N, first idx_valid visible in cycle N+1.
  - No back-to-back overlap: a new bitmask is accepted only in IDLE, so minimum spacing is k+1 cycles.
- Flush:
  - Synchronous, highest priority over handshake and capture.
  - pending<=0, state<=IDLE, no done pulse.
  - A flush in IDLE coincident with req_valid drops the request; req_ready is still shown as 1 that cycle.
- Boundaries:
  - All-ones bitmask emits 0..30 with MASK_ZR=1 (31 indices, last=30), or 0..31 with MASK_ZR=0.
  - Single bit 0 emits idx=0 with idx_last=1.
  - Only bit 31 set with MASK_ZR=1 is treated as empty: done pulse, no emission.
- Reset mid-scan: immediate return to reset values; partially emitted bitmask discarded.
- Outputs are a pure function of registered state (no input-to-output combinational paths except via registers), so the block can sit directly before the register file write address.

Test Plan:
- Reset, then req_vec=32'h0000_0000 with req_valid for 1 cycle -> no idx_valid, done=1 exactly one cycle later, req_ready stays 1.
- req_vec=32'h8000_0025, MASK_ZR=1, idx_ready=1 -> idx sequence 0,2,5 on consecutive cycles, idx_last only with 5, done pulse the cycle after, bit 31 never emitted.
- req_vec=32'hFFFF_FFFF, idx_ready=1 -> 31 indices 0..30 in 31 cycles, busy high throughout, req_ready=0 until after idx=30 accepted.
- Backpressure on req_vec=32'h0000_0110: idx_ready low 3 cycles, then high -> idx=4 held stable with valid for 3 cycles, then 4, 8 emitted, idx_last with 8.
- Flush after first index of 32'h0000_F000 -> after idx=12 accepted, flush=1 -> next cycle idle, req_ready=1, no done; new req 32'h1 then emits idx=0, idx_last=1.
- reset_n asserted asynchronously mid-scan of 32'h00FF_0000 (between clock edges) -> idx_valid=0, busy=0 immediately, no further indices after reset release.
